turn_sequencer: RTL



---
 rtl/turn_sequencer.sv | 89 ++++++++
 1 files changed

// File: rtl/turn_sequencer.sv
// turn_sequencer: per-turn flip/compare/move/end-of-turn sequencer with flip timeout and turn hand-off pulse.
module turn_sequencer #(
  parameter int unsigned FLIP_TIMEOUT = 500_000_000,
  parameter int unsigned TURN_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              flip_valid,
  input  logic              match_valid,
  input  logic              match,
  input  logic              move_done,
  input  logic              win,
  output logic [2:0]        Q,
  output logic              statecombo_next_turn,
  output logic              move_req,
  output logic              game_over,
  output logic [3:0]        chain,
  output logic [TURN_W-1:0] turn_count
);
  localparam int unsigned TW = $clog2(FLIP_TIMEOUT);
  typedef enum logic [2:0] {
    IDLE      = 3'b000,
    WAIT_FLIP = 3'b001,
    COMPARE   = 3'b010,
    MOVE      = 3'b011,
    END_TURN  = 3'b100,
    NEXT      = 3'b101,
    GAME_OVER = 3'b110
  } state_t;
  state_t            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [3:0]        chain_q, chain_d;
  logic [TURN_W-1:0] turn_q, turn_d;
  logic              first_q, first_d;
  logic              clear_game;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      chain_q <= '0;
      turn_q  <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      chain_q <= chain_d;
      turn_q  <= turn_d;
      first_q <= first_d;
    end
  end
  always_comb begin
    state_d = state_q;
    if (abort) state_d = IDLE;
    else begin
      case (state_q)
        IDLE:      if (start) state_d = WAIT_FLIP;
        WAIT_FLIP: begin
          if (flip_valid) state_d = COMPARE;
          else if (timer_q == TW'(FLIP_TIMEOUT - 1)) state_d = END_TURN;
        end
        COMPARE:   if (match_valid) state_d = match ? MOVE : END_TURN;
        MOVE:      if (move_done) state_d = win ? GAME_OVER : WAIT_FLIP;
        END_TURN:  state_d = NEXT;
        NEXT:      state_d = WAIT_FLIP;
        GAME_OVER: if (start) state_d = IDLE;
        default:   state_d = IDLE;
      endcase
    end
  end
  // Every entry into WAIT_FLIP comes from another state, so the timer only runs while we stay there.
  always_comb begin
    clear_game = abort || (state_q == IDLE && start);
    timer_d    = (state_q == WAIT_FLIP && state_d == WAIT_FLIP) ? timer_q + 1'b1 : '0;
    chain_d    = (clear_game || state_q == NEXT) ? 4'd0 :
                 (state_q == MOVE && move_done) ? chain_q + {3'b000, chain_q != 4'hf} : chain_q;
    turn_d     = clear_game ? '0 : (state_q == NEXT) ? turn_q + 1'b1 : turn_q;
    first_d    = state_d == MOVE && state_q != MOVE;
  end
  always_comb begin
    Q                    = state_q;
    statecombo_next_turn = state_q == NEXT;
    move_req             = state_q == MOVE && first_q;
    game_over            = state_q == GAME_OVER;
    chain                = chain_q;
    turn_count           = turn_q;
  end
endmodule
